// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file:
// default sizes, clear-FSM state encoding and packed-slice helpers.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int DEPTH_DEF = 32;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // LSB position of slice k in a packed vector of w-bit fields
   function automatic int lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: write-first bypass, zero-register override and
// the registered output stage.
import regfile_pkg::*;

module regfile_rd_port #(
   parameter int XLEN     = XLEN_DEF,
   parameter int AW       = 5,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic                   re,
   input  logic [AW-1:0]          raddr,
   input  logic [NUM_WR-1:0]      we,
   input  logic [NUM_WR*AW-1:0]   waddr,
   input  logic [NUM_WR*XLEN-1:0] wdata,
   input  logic [XLEN-1:0]        memval,
   output logic [XLEN-1:0]        rdata
);

   logic [XLEN-1:0] val;

   // pick the read value; later write ports override earlier ones
   always_comb begin
      val = memval;
      for (int k = 0; k < NUM_WR; k++) begin
         if (we[k] && waddr[lsb(k, AW) +: AW] == raddr)
            val = wdata[lsb(k, XLEN) +: XLEN];
      end
      if (ZERO_REG != 0 && raddr == '0)
         val = '0;
      if (!run)
         val = '0;
   end

   // registered output, held while re is low
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= '0;
      else if (re)
         rdata <= val;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass and a sequenced
// clear that zeroes one entry per cycle after reset or on request.
import regfile_pkg::*;

module regfile_mp #(
   parameter int XLEN     = XLEN_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int AW       = $clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr_req,
   output logic                   ready,
   input  logic [NUM_WR-1:0]      we,
   input  logic [NUM_WR*AW-1:0]   waddr,
   input  logic [NUM_WR*XLEN-1:0] wdata,
   input  logic [NUM_RD-1:0]      re,
   input  logic [NUM_RD*AW-1:0]   raddr,
   output logic [NUM_RD*XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem [DEPTH];
   state_t          state;
   state_t          state_nx;
   logic [AW-1:0]   clr_ptr;
   logic            run;

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= CLEAR;
      else
         state <= state_nx;
   end

   // next state: leave CLEAR after the last entry is zeroed
   always_comb begin
      state_nx = state;
      case (state)
         CLEAR: if (clr_ptr == AW'(DEPTH - 1)) state_nx = RUN;
         RUN:   if (clr_req) state_nx = CLEAR;
      endcase
   end

   // FSM outputs
   always_comb begin
      run   = (state == RUN);
      ready = run;
   end

   // clear pointer walks every entry once per clear sequence
   always_ff @(posedge clk) begin
      if (rst)
         clr_ptr <= '0;
      else if (!run)
         clr_ptr <= clr_ptr + AW'(1);
      else if (clr_req)
         clr_ptr <= '0;
   end

   // storage: clear one entry, or apply writes with last port winning
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!run) begin
            mem[clr_ptr] <= '0;
         end else begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (we[k] &&
                   !(ZERO_REG != 0 && waddr[lsb(k, AW) +: AW] == '0))
                  mem[waddr[lsb(k, AW) +: AW]] <=
                     wdata[lsb(k, XLEN) +: XLEN];
            end
         end
      end
   end

   for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] mv;

      assign ra = raddr[lsb(j, AW) +: AW];
      assign mv = mem[ra];

      regfile_rd_port #(
         .XLEN     (XLEN),
         .AW       (AW),
         .NUM_WR   (NUM_WR),
         .ZERO_REG (ZERO_REG)
      ) u_rd (
         .clk    (clk),
         .rst    (rst),
         .run    (run),
         .re     (re[j]),
         .raddr  (ra),
         .we     (we),
         .waddr  (waddr),
         .wdata  (wdata),
         .memval (mv),
         .rdata  (rdata[lsb(j, XLEN) +: XLEN])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp: reset and soft-clear
// sequencing, bypass, zero register and write collisions.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_req;
   logic        ready;
   logic [1:0]  we;
   logic [9:0]  waddr;
   logic [63:0] wdata;
   logic [1:0]  re;
   logic [9:0]  raddr;
   logic [63:0] rdata;

   typedef struct {
      string       tag;
      int          port;
      logic [31:0] exp;
   } item_t;

   item_t sb[$];
   int    tests = 0;
   int    fails = 0;
   int    n;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk     (clk),
      .rst     (rst),
      .clr_req (clr_req),
      .ready   (ready),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .re      (re),
      .raddr   (raddr),
      .rdata   (rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      we      = '0;
      re      = '0;
      clr_req = 1'b0;
   endtask

   task automatic wr(input int p, input int a, input logic [31:0] d);
      we[p]           = 1'b1;
      waddr[p*5 +: 5] = 5'(a);
      wdata[p*32 +: 32] = d;
   endtask

   task automatic rd(input int p, input int a, input logic [31:0] e,
                     input string tag);
      item_t it;
      re[p]           = 1'b1;
      raddr[p*5 +: 5] = 5'(a);
      it.tag  = tag;
      it.port = p;
      it.exp  = e;
      sb.push_back(it);
   endtask

   // one clock edge, then compare every read issued before it
   task automatic cyc();
      item_t it;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         chk(it.tag, rdata[it.port*32 +: 32], it.exp);
      end
      idle();
   endtask

   initial begin
      rst   = 1'b1;
      waddr = '0;
      wdata = '0;
      raddr = '0;
      idle();

      // reset state
      cyc();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rdata0", rdata[31:0], 32'd0);
      chk("rst_rdata1", rdata[63:32], 32'd0);
      rst = 1'b0;

      // ready rises exactly DEPTH cycles after reset
      n = 0;
      while (!ready && n < 40) begin
         cyc();
         n++;
      end
      chk("rst_ready_cycles", 32'(n), 32'd32);

      rd(0, 5, 32'd0, "x5_after_reset");
      cyc();

      // basic write then read
      wr(0, 3, 32'hDEADBEEF);
      cyc();
      rd(0, 3, 32'hDEADBEEF, "x3_read");
      cyc();

      // same-cycle bypass
      wr(0, 7, 32'h12345678);
      rd(1, 7, 32'h12345678, "x7_bypass");
      cyc();

      // zero register
      wr(0, 0, 32'hFFFFFFFF);
      rd(1, 0, 32'd0, "x0_bypass");
      cyc();
      rd(0, 0, 32'd0, "x0_read");
      cyc();

      // write collision, last port wins
      wr(0, 9, 32'h1111);
      wr(1, 9, 32'h2222);
      rd(0, 9, 32'h2222, "x9_coll_bypass");
      cyc();
      rd(1, 9, 32'h2222, "x9_coll_read");
      cyc();

      // re low holds output
      raddr[4:0] = 5'd3;
      cyc();
      chk("hold_rdata0", rdata[31:0], 32'h2222);

      // fill x1..x31
      for (int i = 1; i < 32; i++) begin
         wr(0, i, 32'h01010101 * 32'(i) + 32'h100);
         cyc();
      end
      rd(0, 31, 32'h01010101 * 32'd31 + 32'h100, "x31_filled");
      rd(1, 2, 32'h01010101 * 32'd2 + 32'h100, "x2_filled");
      cyc();

      // request clear; this cycle's write and read still complete
      wr(0, 4, 32'hAAAA);
      rd(0, 4, 32'hAAAA, "clr_cycle_bypass");
      clr_req = 1'b1;
      cyc();

      // during CLEAR writes drop, reads return 0
      n = 0;
      while (!ready && n < 40) begin
         wr(0, 2, 32'hBAD);
         rd(1, 20, 32'd0, "clear_read");
         clr_req = 1'b1;
         cyc();
         n++;
      end
      chk("clr_ready_cycles", 32'(n), 32'd32);

      for (int i = 0; i < 32; i += 2) begin
         rd(0, i, 32'd0, "cleared_even");
         rd(1, i + 1, 32'd0, "cleared_odd");
         cyc();
      end

      // reset in the middle of a clear
      wr(0, 5, 32'h77);
      cyc();
      rd(0, 5, 32'h77, "x5_pre_rst0");
      rd(1, 5, 32'h77, "x5_pre_rst1");
      cyc();
      clr_req = 1'b1;
      cyc();
      for (int i = 0; i < 10; i++)
         cyc();
      chk("midclr_ready", 32'(ready), 32'd0);
      chk("midclr_hold", rdata[31:0], 32'h77);
      rst = 1'b1;
      cyc();
      chk("midclr_rst_rd0", rdata[31:0], 32'd0);
      chk("midclr_rst_rd1", rdata[63:32], 32'd0);
      rst = 1'b0;
      n = 0;
      while (!ready && n < 40) begin
         cyc();
         n++;
      end
      chk("midclr_ready_cycles", 32'(n), 32'd32);
      rd(0, 5, 32'd0, "x5_after_midclr");
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
